// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable, mux select and the AluOp code for aluControl.
// Optional build macro MULTICYCLE_CONTROL_PERF_EN adds the instr_count and
// stall_count performance counters as extra output ports.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] AluOp,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       illegal_op
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] OP_R    = 4'b0000;
  localparam logic [OpW-1:0] OP_ADDI = 4'b0001;
  localparam logic [OpW-1:0] OP_ANDI = 4'b0010;
  localparam logic [OpW-1:0] OP_ORI  = 4'b0011;
  localparam logic [OpW-1:0] OP_LW   = 4'b0100;
  localparam logic [OpW-1:0] OP_SW   = 4'b0101;
  localparam logic [OpW-1:0] OP_BEQ  = 4'b0110;
  localparam logic [OpW-1:0] OP_BNE  = 4'b0111;
  localparam logic [OpW-1:0] OP_J    = 4'b1000;
  localparam logic [OpW-1:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_ADD   = 4'b1010;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_SUB   = 4'b1110;
  localparam logic [3:0] ALU_FUNCT = 4'b0000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_MEM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and control outputs; reset masks every enable and status flag
  always_comb begin
    w_next     = r_state;
    AluOp      = ALU_ADD;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:                     w_next = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
          OP_LW, OP_SW:             w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           w_next = S_BRANCH;
          OP_J:                     w_next = S_JUMP;
          OP_HALT:                  w_next = S_HALT;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        AluOp     = ALU_FUNCT;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_ANDI: begin alu_src_b = 2'b11; AluOp = ALU_AND; end
          OP_ORI:  begin alu_src_b = 2'b11; AluOp = ALU_OR;  end
          default: begin alu_src_b = 2'b10; AluOp = ALU_ADD; end
        endcase
        w_next = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        AluOp     = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      illegal_op = 1'b0;
    end
  end

`ifdef MULTICYCLE_CONTROL_PERF_EN
  localparam int unsigned CntW = 32;

  logic [CntW-1:0] r_instr_count;
  logic [CntW-1:0] r_stall_count;
  logic            w_retire;
  logic            w_stall;

  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);
  assign w_stall  = !mem_ready && ((r_state == S_FETCH) ||
                                   (r_state == S_MEM_READ) ||
                                   (r_state == S_MEM_WRITE));

  // Retired-instruction and memory-stall counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_retire) r_instr_count <= r_instr_count + CntW'(1);
      if (w_stall)  r_stall_count <= r_stall_count + CntW'(1);
    end
  end

  assign instr_count = r_instr_count;
  assign stall_count = r_stall_count;
`endif

endmodule
